// File: rtl/mantissa_shift_add_multiplier_if.sv
// Handshake/data bundle for the mantissa shift-add multiplier.
//   start   : request, sampled only while the multiplier is idle
//   q, m    : multiplier / multiplicand operands, latched on an accepted start
//   busy    : high from acceptance until the product is written
//   done    : one-cycle pulse, p is valid
//   p       : full 2*Width-bit product, held until the next result
//   norm_hi : p MSB; 1 means product in [2,4)
// master = requester (FPU control / bench), slave = multiplier.
interface mantissa_shift_add_multiplier_if #(
  parameter int unsigned Width = 24
);
  logic                 start;
  logic [Width-1:0]     q;
  logic [Width-1:0]     m;
  logic                 busy;
  logic                 done;
  logic [2*Width-1:0]   p;
  logic                 norm_hi;

  modport master (
    output start, q, m,
    input  busy, done, p, norm_hi
  );

  modport slave (
    input  start, q, m,
    output busy, done, p, norm_hi
  );
endinterface

// File: rtl/mantissa_shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier for FP mantissas (hidden bit included).
// One partial-product step per clock; fixed latency independent of operand values.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, aborts any in-flight operation
//   bus : slave side of mantissa_shift_add_multiplier_if (start/q/m in,
//         busy/done/p/norm_hi out)
module mantissa_shift_add_multiplier #(
  parameter int unsigned Width = 24
) (
  input logic                           clk,
  input logic                           rst,
  mantissa_shift_add_multiplier_if.slave bus
);

  localparam int unsigned CntW = $clog2(Width + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [Width-1:0]   mr_q;
  logic [Width-1:0]   qr_q;
  logic [Width-1:0]   a_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*Width-1:0] p_q;
  logic               busy_q;
  logic               done_q;

  // {carry, A} after conditionally adding the multiplicand. The carry is
  // always shifted into A's MSB in the same cycle, so it never needs storing.
  logic [Width-1:0]   addend;
  logic [Width:0]     sum;

  assign addend = qr_q[0] ? mr_q : '0;
  assign sum    = {1'b0, a_q} + {1'b0, addend};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mr_q    <= '0;
      qr_q    <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mr_q    <= bus.m;
            qr_q    <= bus.q;
            a_q     <= '0;
            cnt_q   <= CntW'(Width);
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          // {C,A,Qr} >> 1 with {C,A} = sum
          a_q   <= sum[Width:1];
          qr_q  <= {sum[0], qr_q[Width-1:1]};
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          p_q     <= {a_q, qr_q};
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.p       = p_q;
  assign bus.norm_hi = p_q[2*Width-1];

endmodule

// File: tb/tb_mantissa_shift_add_multiplier.sv
module tb_mantissa_shift_add_multiplier;
  localparam int unsigned Width = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mantissa_shift_add_multiplier_if #(.Width(Width)) bus ();

  mantissa_shift_add_multiplier #(.Width(Width)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2*Width-1:0] p;
    int                 acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no result (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", 64'(bus.p), 64'(e.p));
        check("norm_hi", 64'(bus.norm_hi), 64'(e.p[2*Width-1]));
        check("latency", 64'(cyc), 64'(e.acc + int'(Width) + 1));
        check("busy_in_done_cycle", 64'(bus.busy), 64'd0);
      end
    end
  end

  task automatic op(input logic [Width-1:0] q, input logic [Width-1:0] m,
                    input logic [2*Width-1:0] exp_p);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < int'(Width) + 4) begin
      @(negedge clk);
      n++;
    end
    if (n >= int'(Width) + 4) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy=%b expected 0", bus.busy);
    end
    bus.start = 1'b1;
    bus.q     = q;
    bus.m     = m;
    e.p   = exp_p;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    // operands are latched; scrambling them must not matter
    bus.q = Width'($urandom);
    bus.m = Width'($urandom);
    check("busy_after_accept", 64'(bus.busy), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4 * int'(Width)) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    bus.start = 1'b0;
    bus.q     = '0;
    bus.m     = '0;
    #2 rst = 1'b1;
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_p", 64'(bus.p), 64'd0);
    check("reset_norm_hi", 64'(bus.norm_hi), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    op(24'd3, 24'd8, 48'd24);
    op(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    op(24'hC00000, 24'hC00000, 48'h900000000000);
    op(24'h800000, 24'h800000, 48'h400000000000);
    op(24'd0, 24'h9ABCDE, 48'd0);
    op(24'hABCDEF, 24'd2, 48'h1579BDE);
    drain();

    // start pulse mid-RUN is ignored
    op(24'd5, 24'd7, 48'd35);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.q     = 24'd9;
    bus.m     = 24'd9;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (Width + 4) @(negedge clk);

    // start held high: two back-to-back operations
    @(negedge clk);
    bus.start = 1'b1;
    bus.q     = 24'd3;
    bus.m     = 24'd8;
    e.p   = 48'd24;
    e.acc = cyc + 1;
    sb.push_back(e);
    e.acc = cyc + 1 + int'(Width) + 2;
    sb.push_back(e);
    repeat (Width + 3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // async reset mid-RUN aborts the operation
    op(24'd9, 24'd11, 48'd99);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_p", 64'(bus.p), 64'd0);
    check("abort_norm_hi", 64'(bus.norm_hi), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (Width + 4) @(negedge clk);
    op(24'd2, 24'd3, 48'd6);
    drain();
    repeat (Width + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
